// File: rtl/pipelined_comparator.sv
// ---------------------------------------------------------------------------
// pipelined_comparator
//
// Compares two WIDTH-bit operands, either as unsigned magnitudes or as
// two's-complement values, and delivers a one-hot eq/lt/gt result through a
// single output register one cycle after the operands are accepted. Also
// keeps saturating per-outcome statistics counters.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. The producer holds its payload stable while
// valid && !ready. The input side is ready whenever the output register is
// empty or is being drained this cycle (in_ready = !out_valid || out_ready),
// so a full-throughput stream needs no bubble.
//
// Parameters
//   WIDTH       operand width in bits (2..64)
//   CNT_W       width of each statistics counter
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake for a, b, signed_mode
//   a, b                      operands
//   signed_mode               1 = two's-complement compare, 0 = unsigned
//   out_valid/out_ready       output handshake for eq/lt/gt
//   eq, lt, gt                registered one-hot result (all 0 when idle)
//   clr_cnt                   synchronous clear of the statistics counters
//   eq_cnt, lt_cnt, gt_cnt    saturating count of accepted transactions
// ---------------------------------------------------------------------------
module pipelined_comparator #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             accept;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             eq_n;
    logic             lt_n;
    logic             gt_n;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Flipping the MSB in signed mode maps two's-complement order onto
    // unsigned order, so one unsigned comparator serves both modes.
    assign a_key = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    assign b_key = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};

    assign eq_n = (a == b);
    assign lt_n = (a_key < b_key);
    assign gt_n = !eq_n && !lt_n;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // Output register: load on accept, drain on out_ready, otherwise hold.
    // Flags are cleared when draining so an idle output reads all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            eq        <= eq_n;
            lt        <= lt_n;
            gt        <= gt_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end
    end

    // Statistics: a clear coinciding with an accepted transaction leaves the
    // matching counter at 1, since the clear applies before the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_cnt <= '0;
            lt_cnt <= '0;
            gt_cnt <= '0;
        end else begin
            if (clr_cnt) begin
                eq_cnt <= '0;
                lt_cnt <= '0;
                gt_cnt <= '0;
            end
            if (accept) begin
                if (eq_n) eq_cnt <= clr_cnt ? CNT_ONE : sat_inc(eq_cnt);
                if (lt_n) lt_cnt <= clr_cnt ? CNT_ONE : sat_inc(lt_cnt);
                if (gt_n) gt_cnt <= clr_cnt ? CNT_ONE : sat_inc(gt_cnt);
            end
        end
    end

endmodule

// File: doc/pipelined_comparator.md
PIPELINED_COMPARATOR -- requirements
Module: pipelined_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 20, meaning operand width in bits (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each result-statistics counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b/signed_mode is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
REQ-010 SHALL have port out_valid  output  1  eq/lt/gt hold a valid result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 SHALL have port eq  output  1  registered a == b.
REQ-013 SHALL have port lt  output  1  registered a < b under sampled mode.
REQ-014 SHALL have port gt  output  1  registered a > b under sampled mode.
REQ-015 SHALL have port clr_cnt  input  1  synchronous clear of all statistics counters.
REQ-016 SHALL have ports eq_cnt, lt_cnt, gt_cnt  output  CNT_W each  count of accepted transactions per outcome.

Function
REQ-017 SHALL accept a transaction in any cycle where in_valid && in_ready (input handshake).
REQ-018 SHALL drive in_ready = !out_valid || out_ready (single output register, combinational pass-through of backpressure, no bubble).
REQ-019 SHALL present the result of an accepted transaction with out_valid = 1 in the cycle after acceptance (latency 1).
REQ-020 SHALL hold eq/lt/gt and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on out_valid && out_ready unless a new transaction is accepted in the same cycle, in which case out_valid stays 1 and the new result is loaded.
REQ-022 SHALL guarantee exactly one of eq/lt/gt is 1 whenever out_valid = 1; all three 0 when out_valid = 0.
REQ-023 SHALL compare with MSB as sign bit when signed_mode = 1, and as magnitude bit when 0.
REQ-024 SHALL increment exactly one of eq_cnt/lt_cnt/gt_cnt by 1 per accepted transaction, in the cycle of acceptance (visible next cycle).
REQ-025 SHALL saturate each counter at 2^CNT_W - 1; no wrap-around.
REQ-026 SHALL, when clr_cnt = 1, set all counters to 0; if a transaction is accepted in the same cycle, the matching counter SHALL become 1 and others 0.
REQ-027 SHALL ignore a, b, signed_mode when no input handshake occurs.

Reset
REQ-028 SHALL, on rst_n = 0, immediately force out_valid = 0, eq = lt = gt = 0, all counters = 0, independent of clk.
REQ-029 SHALL drive in_ready = 1 while in reset and in the first cycle after release.
REQ-030 SHALL discard any pending (unconsumed) result when reset is asserted mid-transaction; no result is emitted after release without a new handshake.

Verification
REQ-031 SHALL cover unsigned compare: WIDTH=20, a=0x80000, b=0x00001, signed_mode=0 -> next cycle gt=1, gt_cnt=1.
REQ-032 SHALL cover signed compare: same operands, signed_mode=1 -> lt=1; a=b=0xFFFFF -> eq=1 in both modes.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles after a result -> result held, in_ready=0, second pair not accepted; out_ready=1 with in_valid=1 -> back-to-back results, one per cycle.
REQ-034 SHALL cover saturation: CNT_W=4, 20 equal pairs -> eq_cnt=15; clr_cnt with simultaneous equal pair -> eq_cnt=1.
REQ-035 SHALL cover async reset mid-stall: rst_n low between clock edges with out_valid=1 -> outputs and counters 0 before next edge, no result after release.
REQ-036 SHALL cover random streams (both modes, random valid/ready) against a reference model: one-hot result, in-order delivery, counters matching totals.
